// File: rtl/isa_pkg.sv
// MIPS subset shared with the control decoder: mnemonic codes, opcode/funct values
// and the combinational field packer used by the instruction encoder.
package isa_pkg;

    typedef enum logic [4:0] {
        SLLV = 5'd0, SRLV, SRAV, JR, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR,
        J, BEQ, BNE, BLEZ, BGTZ, ADDI, ADDIU, ANDI, ORI, XORI, LW, SW
    } mnem_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Fields a format does not use are simply never referenced, so they cannot leak.
    function automatic enc_t encode(input logic [4:0] mnem, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [15:0] imm, input logic [25:0] target);
        enc_t e;
        e.ok   = 1'b1;
        e.word = '0;
        case (mnem)
            SLLV:    e.word = rtype(rs, rt, rd, FN_SLLV);
            SRLV:    e.word = rtype(rs, rt, rd, FN_SRLV);
            SRAV:    e.word = rtype(rs, rt, rd, FN_SRAV);
            JR:      e.word = rtype(rs, 5'd0, 5'd0, FN_JR);
            ADD:     e.word = rtype(rs, rt, rd, FN_ADD);
            ADDU:    e.word = rtype(rs, rt, rd, FN_ADDU);
            SUB:     e.word = rtype(rs, rt, rd, FN_SUB);
            SUBU:    e.word = rtype(rs, rt, rd, FN_SUBU);
            AND:     e.word = rtype(rs, rt, rd, FN_AND);
            OR:      e.word = rtype(rs, rt, rd, FN_OR);
            XOR:     e.word = rtype(rs, rt, rd, FN_XOR);
            NOR:     e.word = rtype(rs, rt, rd, FN_NOR);
            J:       e.word = {OP_J, target};
            BEQ:     e.word = itype(OP_BEQ, rs, rt, imm);
            BNE:     e.word = itype(OP_BNE, rs, rt, imm);
            BLEZ:    e.word = itype(OP_BLEZ, rs, 5'd0, imm);
            BGTZ:    e.word = itype(OP_BGTZ, rs, 5'd0, imm);
            ADDI:    e.word = itype(OP_ADDI, rs, rt, imm);
            ADDIU:   e.word = itype(OP_ADDIU, rs, rt, imm);
            ANDI:    e.word = itype(OP_ANDI, rs, rt, imm);
            ORI:     e.word = itype(OP_ORI, rs, rt, imm);
            XORI:    e.word = itype(OP_XORI, rs, rt, imm);
            LW:      e.word = itype(OP_LW, rs, rt, imm);
            SW:      e.word = itype(OP_SW, rs, rt, imm);
            default: e.ok   = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder: field input handshake and word output handshake.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        err;

    modport master (
        output in_valid, mnem, rs, rt, rd, imm, target, out_ready,
        input  in_ready, out_valid, out_word, err
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, imm, target, out_ready,
        output in_ready, out_valid, out_word, err
    );

endinterface

// File: rtl/enc_fifo.sv
// Small power-of-two FIFO whose head is held in a register, so the output word
// keeps the last popped value while the FIFO is empty.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] head_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = head_q;
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // On a pop the head reloads from the next stored entry, or from the incoming
    // word when that entry is being written in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (do_pop) begin
                if (cnt > CW'(1)) begin
                    head_q <= mem[rd_ptr + PW'(1)];
                end else if (do_push) begin
                    head_q <= wdata;
                end
            end else if (do_push && empty) begin
                head_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs mnemonic + register/immediate fields into 32-bit MIPS words, buffered in enc_fifo.
// Optional ENC_STATS_EN adds saturating counters of pushed words and unsupported mnemonics.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_encoder_if.slave    bus
`ifdef ENC_STATS_EN
    ,
    output logic [15:0]       enc_count,
    output logic [7:0]        err_count
`endif
);

    import isa_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    enc_t          enc;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   head;
    logic          err_q;

    always_comb begin
        enc = encode(bus.mnem, bus.rs, bus.rt, bus.rd, bus.imm, bus.target);
    end

    // No pop bypass: a full FIFO refuses input even while its head is being taken.
    assign bus.in_ready  = (fifo_count < CW'(DEPTH));
    assign accept        = bus.in_valid && bus.in_ready;
    assign push          = accept && enc.ok;
    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_word  = head;
    assign bus.err       = err_q;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (enc.word),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !enc.ok;
        end
    end

`ifdef ENC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (push && (enc_count != 16'hFFFF)) begin
                enc_count <= enc_count + 16'd1;
            end
            if (accept && !enc.ok && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`endif

endmodule
